// File: rtl/aclint_memory_if.sv
// Request/response bus between the memory interconnect and the ACLINT block.
// Single-beat 64-bit transfers; the offset is already local to the block.
interface aclint_memory_if #(
  parameter int OFFSET_WIDTH = 16
) ();
  logic                    req_valid;
  logic                    req_ready;
  logic [OFFSET_WIDTH-1:0] req_addr;
  logic                    req_wen;
  logic [63:0]             req_wdata;
  logic [7:0]              req_wmask;
  logic                    rsp_valid;
  logic [63:0]             rsp_rdata;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/aclint_memory.sv
// ACLINT for hart 0: MSWI (msip) and MTIMER (mtime, mtimecmp) behind a
// single-beat 64-bit bus. Every request is accepted; a response follows
// exactly one cycle later. mtime advances once every TICK_DIV cycles.
module aclint_memory #(
  parameter int TICK_DIV     = 1,
  parameter int OFFSET_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  aclint_memory_if.slave     bus,
  output logic               mtip,
  output logic               msip,
  output logic [63:0]        mtime
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  // Doubleword indices (byte offset >> 3) of the mapped registers.
  localparam int DW_W        = OFFSET_WIDTH - 3;
  localparam int DW_MSIP     = 32'h0000_0000 >> 3;
  localparam int DW_MTIMECMP = 32'h0000_4000 >> 3;
  localparam int DW_MTIME    = 32'h0000_BFF8 >> 3;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_MSIP,
    REG_MTIMECMP,
    REG_MTIME
  } reg_sel_e;

  // Byte-granular merge of write data into an existing register value.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  mask);
    logic [63:0] res;
    res = old_v;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        res[i*8 +: 8] = new_v[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = old_v[i*8 +: 8];
      end
    end
    return res;
  endfunction

  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      mtimecmp_q, mtimecmp_d;
  logic             msip_q, msip_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [63:0]      rsp_rdata_q, rsp_rdata_d;

  logic             accept_s;
  logic             wr_s;
  logic             rd_s;
  logic             tick_s;
  reg_sel_e         reg_sel_s;
  logic [63:0]      rd_val_s;
  logic             unused_addr_s;

  // The block never back-pressures.
  assign bus.req_ready = 1'b1;
  assign accept_s      = bus.req_valid & bus.req_ready;
  assign wr_s          = accept_s & bus.req_wen;
  assign rd_s          = accept_s & ~bus.req_wen;
  assign tick_s        = (tick_cnt_q == CNT_MAX);
  // Sub-doubleword address bits do not take part in decode.
  assign unused_addr_s = ^bus.req_addr[2:0];

  // Decode the doubleword offset to a register select.
  always_comb begin
    reg_sel_s = REG_NONE;
    if (bus.req_addr[OFFSET_WIDTH-1:3] == DW_W'(DW_MSIP)) begin
      reg_sel_s = REG_MSIP;
    end else if (bus.req_addr[OFFSET_WIDTH-1:3] == DW_W'(DW_MTIMECMP)) begin
      reg_sel_s = REG_MTIMECMP;
    end else if (bus.req_addr[OFFSET_WIDTH-1:3] == DW_W'(DW_MTIME)) begin
      reg_sel_s = REG_MTIME;
    end else begin
      reg_sel_s = REG_NONE;
    end
  end

  // Read mux on current register values (before this cycle's updates).
  always_comb begin
    rd_val_s = 64'h0;
    case (reg_sel_s)
      REG_MSIP:     rd_val_s = {63'h0, msip_q};
      REG_MTIMECMP: rd_val_s = mtimecmp_q;
      REG_MTIME:    rd_val_s = mtime_q;
      default:      rd_val_s = 64'h0;
    endcase
  end

  // Next-state for prescaler, timer registers, msip and the response.
  always_comb begin
    tick_cnt_d  = tick_cnt_q;
    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;
    msip_d      = msip_q;
    rsp_valid_d = accept_s;
    rsp_rdata_d = 64'h0;

    // Prescaler free-runs; bus traffic never disturbs it.
    if (tick_s) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + CNT_W'(1);
    end

    // A software write to mtime wins over the tick increment.
    if (wr_s && (reg_sel_s == REG_MTIME)) begin
      mtime_d = merge_bytes(mtime_q, bus.req_wdata, bus.req_wmask);
    end else if (tick_s) begin
      mtime_d = mtime_q + 64'd1;
    end else begin
      mtime_d = mtime_q;
    end

    if (wr_s && (reg_sel_s == REG_MTIMECMP)) begin
      mtimecmp_d = merge_bytes(mtimecmp_q, bus.req_wdata, bus.req_wmask);
    end else begin
      mtimecmp_d = mtimecmp_q;
    end

    // Only byte lane 0 bit 0 is backed by storage.
    if (wr_s && (reg_sel_s == REG_MSIP) && bus.req_wmask[0]) begin
      msip_d = bus.req_wdata[0];
    end else begin
      msip_d = msip_q;
    end

    if (rd_s) begin
      rsp_rdata_d = rd_val_s;
    end else begin
      rsp_rdata_d = 64'h0;
    end
  end

  // State registers; reset drops any in-flight response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q  <= '0;
      mtime_q     <= 64'h0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 64'h0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign mtip          = (mtime_q >= mtimecmp_q);
  assign msip          = msip_q;
  assign mtime         = mtime_q;

endmodule
